debug_cmd_rx: RTL
=================

# debug_cmd_rx

Receive-side command parser for the debug UART console. It consumes bytes from the UART receiver's `rxd`/`rxv` strobe and parses ASCII lines of the form `R aa` or `W aa dddd`, terminated by CR or LF. Each valid line becomes one register read or write request on a valid/ready interface toward the PHY/MDIO register-access logic. The block is the inbound counterpart of the periodic debug status printer.

## Interface
Parameters:
- `TIMEOUT_TICKS`, default 25000000: idle clocks allowed between bytes inside a partial line before the line is aborted.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rxd` in 8: received byte; valid only when `rxv`=1.
- `rxv` in 1: single-cycle byte strobe from the UART receiver.
- `cmd_v` out 1: command valid; held until accepted.
- `cmd_rdy` in 1: consumer ready; transfer occurs when `cmd_v && cmd_rdy`.
- `cmd_we` out 1: 1 = write, 0 = read.
- `cmd_addr` out 8: register address (2 hex digits, first digit is the MSB nibble).
- `cmd_data` out 16: write data (4 hex digits, MSB first); 0 for reads.
- `err` out 1: one-cycle pulse when a line is rejected (syntax error or timeout).
- `ovf` out 1: one-cycle pulse when a byte is dropped while a command is pending.

## Operation
- Character classes:
  - Hex digits: `0-9`, `a-f`, `A-F`, case-insensitive.
  - EOL: 8'h0d or 8'h0a.
  - SP: 8'h20.
  - Opcodes: `R`/`r` and `W`/`w`.
- States: IDLE, SP1, ADDR, SP2, DATA, EOL, HOLD, DISCARD. Each transition below is taken on a cycle with `rxv`=1.
- IDLE:
  - Opcode: latch `we`, clear `addr`/`data`, go to SP1.
  - EOL: stay in IDLE silently, so CRLF and blank lines produce nothing.
  - Any other byte: go to DISCARD.
- SP1: SP goes to ADDR with the digit counter at 0.
- ADDR:
  - Hex digit: `addr <= {addr[3:0], nib}` and increment the counter.
  - After the 2nd digit: go to SP2 if `we`=1, else EOL.
- SP2: SP goes to DATA with the counter at 0.
- DATA: each hex digit does `data <= {data[11:0], nib}`. After the 4th digit go to EOL.
- EOL: an EOL byte goes to HOLD and sets `cmd_v`.
- Unexpected byte in SP1/ADDR/SP2/DATA/EOL:
  - If the byte is EOL: pulse `err` and go to IDLE.
  - Otherwise: go to DISCARD.
- DISCARD: drop bytes until an EOL byte, then pulse `err` and go to IDLE.
- HOLD:
  - `cmd_v`=1; `cmd_we`, `cmd_addr` and `cmd_data` are stable.
  - On `cmd_rdy`=1, deassert `cmd_v` and go to IDLE.
  - Any `rxv` in HOLD drops the byte and pulses `ovf`. There is no buffering.
- Timeout:
  - The counter clears on every `rxv` and in IDLE/HOLD, and counts up in every other state.
  - At `TIMEOUT_TICKS-1`, pulse `err` and go to IDLE.
  - If `rxv` arrives in the same cycle, the byte wins: it is processed and the counter clears.
- Extra digits: a 3rd address digit, or a data field on a read, reaches EOL as a non-EOL byte and is handled as DISCARD, i.e. `err`.

## Timing
- Reset values: `cmd_v`=0, `cmd_we`=0, `cmd_addr`=0, `cmd_data`=0, `err`=0, `ovf`=0. State = IDLE, counters = 0.
- Latency: `cmd_v` rises the cycle after the terminating EOL byte's `rxv`.
- Acceptance: `cmd_v` falls the cycle after `cmd_v && cmd_rdy`. The earliest next command is the following line.
- `cmd_rdy` asserted before `cmd_v` has no effect. The handshake is evaluated only while in HOLD.
- `err` and `ovf` are asserted for exactly one cycle, registered the cycle after the triggering byte or timeout.
- Counter width is `$clog2(TIMEOUT_TICKS+1)`. The address digit counter is 1 bit; the data digit counter is 2 bits.
- `rst` mid-line or in HOLD returns to IDLE next cycle and drops `cmd_v` with no `err`.

## Structure
- Shared package `debug_pkg`:
  - Constants `ASCII_CR`, `ASCII_LF`, `ASCII_SP`.
  - Function `is_hex(byte)`.
  - Function `ascii2nib(byte)` returning 4 bits.
  - State enum typedef `cmd_rx_state_t`.
- No sub-module. The block is a single FSM plus datapath registers. The UART itself is instantiated by the parent.

## Test plan
- `"W 1F 12aB\r"` then `cmd_rdy`=1 → one transfer with `cmd_we`=1, `cmd_addr`=8'h1f, `cmd_data`=16'h12ab; `cmd_v` rises 1 cycle after `\r`.
- `"r 02\r\n"` with `cmd_rdy`=0 for 10 cycles → `cmd_v` held 10+ cycles with fields stable (`cmd_we`=0, `cmd_addr`=8'h02, `cmd_data`=0). The `\n` is dropped with `ovf`=1 for 1 cycle, and no second command is produced.
- `"W 1G 0000\r"` → `err` pulses once after `\r`, no `cmd_v`; a following `"R 05\r"` is accepted normally.
- `TIMEOUT_TICKS`=100: `"W 1"` then 100 idle cycles → single `err` pulse and IDLE. Then `"R 05\r"` → `cmd_addr`=8'h05.
- `"\r\n\r\n"` → no `err`, no `cmd_v`. `"X\r"` → one `err`.
- `rst` pulsed while in HOLD → `cmd_v`=0 next cycle, no `err`, and the next line parses correctly.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the debug console: ASCII constants, character
// classification helpers and the command-receiver state encoding.
package debug_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0d;
    localparam logic [7:0] ASCII_LF = 8'h0a;
    localparam logic [7:0] ASCII_SP = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SP1     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_SP2     = 3'd3,
        ST_DATA    = 3'd4,
        ST_EOL     = 3'd5,
        ST_HOLD    = 3'd6,
        ST_DISCARD = 3'd7
    } cmd_rx_state_t;

    function automatic logic is_hex(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) ||
               ((b >= 8'h41) && (b <= 8'h46)) ||
               ((b >= 8'h61) && (b <= 8'h66));
    endfunction

    // Letters 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
    function automatic logic [3:0] ascii2nib(input logic [7:0] b);
        logic [3:0] nib;
        if (b <= 8'h39) begin
            nib = b[3:0];
        end else begin
            nib = b[3:0] + 4'd9;
        end
        return nib;
    endfunction

    function automatic logic is_eol(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

    function automatic logic is_op(input logic [7:0] b);
        return (b == 8'h52) || (b == 8'h72) || (b == 8'h57) || (b == 8'h77);
    endfunction

endpackage

// File: rtl/debug_cmd_rx.sv
// Debug console command parser: turns "R aa" / "W aa dddd" lines from the
// UART receiver into single register read/write requests.
module debug_cmd_rx
    import debug_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxd,
    input  logic        rxv,
    output logic        cmd_v,
    input  logic        cmd_rdy,
    output logic        cmd_we,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        err,
    output logic        ovf
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    cmd_rx_state_t state_r, state_s, bad_state_s;
    logic          we_r, we_s;
    logic [7:0]    addr_r, addr_s;
    logic [15:0]   data_r, data_s;
    logic          acnt_r, acnt_s;
    logic [1:0]    dcnt_r, dcnt_s;
    logic [TW-1:0] tmo_r, tmo_s;
    logic          cmd_v_r, cmd_v_s;
    logic          err_r, err_s;
    logic          ovf_r, ovf_s;
    logic          eol_s;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            we_r    <= 1'b0;
            addr_r  <= 8'h00;
            data_r  <= 16'h0000;
            acnt_r  <= 1'b0;
            dcnt_r  <= 2'd0;
            tmo_r   <= '0;
            cmd_v_r <= 1'b0;
            err_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            we_r    <= we_s;
            addr_r  <= addr_s;
            data_r  <= data_s;
            acnt_r  <= acnt_s;
            dcnt_r  <= dcnt_s;
            tmo_r   <= tmo_s;
            cmd_v_r <= cmd_v_s;
            err_r   <= err_s;
            ovf_r   <= ovf_s;
        end
    end

    // Next-state, field assembly, handshake and timeout.
    always_comb begin
        state_s     = state_r;
        we_s        = we_r;
        addr_s      = addr_r;
        data_s      = data_r;
        acnt_s      = acnt_r;
        dcnt_s      = dcnt_r;
        cmd_v_s     = cmd_v_r;
        err_s       = 1'b0;
        ovf_s       = 1'b0;
        eol_s       = is_eol(rxd);
        bad_state_s = eol_s ? ST_IDLE : ST_DISCARD;

        if (rxv || (state_r == ST_IDLE) || (state_r == ST_HOLD)) begin
            tmo_s = '0;
        end else begin
            tmo_s = tmo_r + TMO_ONE;
        end

        if (state_r == ST_HOLD) begin
            ovf_s = rxv;
            if (cmd_rdy) begin
                cmd_v_s = 1'b0;
                state_s = ST_IDLE;
            end else begin
                cmd_v_s = 1'b1;
            end
        end else if (rxv) begin
            // An unexpected EOL aborts with err at once; other junk waits for EOL.
            case (state_r)
                ST_IDLE: begin
                    if (is_op(rxd)) begin
                        we_s    = (rxd == 8'h57) || (rxd == 8'h77);
                        addr_s  = 8'h00;
                        data_s  = 16'h0000;
                        state_s = ST_SP1;
                    end else begin
                        state_s = bad_state_s;
                    end
                end
                ST_SP1: begin
                    if (rxd == ASCII_SP) begin
                        acnt_s  = 1'b0;
                        state_s = ST_ADDR;
                    end else begin
                        state_s = bad_state_s;
                        err_s   = eol_s;
                    end
                end
                ST_ADDR: begin
                    if (is_hex(rxd)) begin
                        addr_s  = {addr_r[3:0], ascii2nib(rxd)};
                        acnt_s  = ~acnt_r;
                        if (acnt_r) begin
                            state_s = we_r ? ST_SP2 : ST_EOL;
                        end else begin
                            state_s = ST_ADDR;
                        end
                    end else begin
                        state_s = bad_state_s;
                        err_s   = eol_s;
                    end
                end
                ST_SP2: begin
                    if (rxd == ASCII_SP) begin
                        dcnt_s  = 2'd0;
                        state_s = ST_DATA;
                    end else begin
                        state_s = bad_state_s;
                        err_s   = eol_s;
                    end
                end
                ST_DATA: begin
                    if (is_hex(rxd)) begin
                        data_s = {data_r[11:0], ascii2nib(rxd)};
                        dcnt_s = dcnt_r + 2'd1;
                        if (dcnt_r == 2'd3) begin
                            state_s = ST_EOL;
                        end else begin
                            state_s = ST_DATA;
                        end
                    end else begin
                        state_s = bad_state_s;
                        err_s   = eol_s;
                    end
                end
                ST_EOL: begin
                    if (eol_s) begin
                        cmd_v_s = 1'b1;
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    state_s = bad_state_s;
                    err_s   = eol_s;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else if ((state_r != ST_IDLE) && (tmo_r == TMO_LAST)) begin
            err_s   = 1'b1;
            tmo_s   = '0;
            state_s = ST_IDLE;
        end else begin
            state_s = state_r;
        end
    end

    assign cmd_v    = cmd_v_r;
    assign cmd_we   = we_r;
    assign cmd_addr = addr_r;
    assign cmd_data = data_r;
    assign err      = err_r;
    assign ovf      = ovf_r;

endmodule
